// File: rtl/fb_db_ctrl.sv
// fb_db_ctrl: double-buffered framebuffer controller (clear, draw, swap on vblank)
//   clk, rst                         pixel clock, async active-high reset
//   vbi                              start-of-vblank pulse
//   clr_cidx                         clear colour, latched when a frame is accepted
//   draw_start / draw_done           frame handshake with the drawing engine
//   draw_we, draw_addr, draw_cidx    drawing engine write request
//   fb_we, fb_addr, fb_cidx          registered back-buffer write port
//   fb_draw                          back-buffer select (0: draw fb0, show fb1)
//   busy, overrun                    CLEAR/DRAW active, vbi-before-frame-done pulse
//   Macro FB_DB_CLEAR_EN enables the clear pass before each frame.
module fb_db_ctrl #(
   parameter int FB_ADDRW  = 17,
   parameter int FB_DATAW  = 4,
   parameter int FB_PIXELS = 76800
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                vbi,
   input  logic [FB_DATAW-1:0] clr_cidx,
   output logic                draw_start,
   input  logic                draw_done,
   input  logic                draw_we,
   input  logic [FB_ADDRW-1:0] draw_addr,
   input  logic [FB_DATAW-1:0] draw_cidx,
   output logic                fb_we,
   output logic [FB_ADDRW-1:0] fb_addr,
   output logic [FB_DATAW-1:0] fb_cidx,
   output logic                fb_draw,
   output logic                busy,
   output logic                overrun
);
   typedef enum logic [1:0] {IDLE, CLEAR, DRAW, READY} state_t;
   state_t state, state_nxt;
   logic accept, clr_last, start_nxt, fb_we_nxt;
   logic [FB_ADDRW-1:0] fb_addr_nxt;
   logic [FB_DATAW-1:0] fb_cidx_nxt;
   assign accept = vbi && (state == IDLE || state == READY);
`ifdef FB_DB_CLEAR_EN
   localparam int CW = $clog2(FB_PIXELS);
   localparam state_t START_ST = CLEAR;
   logic [CW-1:0] clr_addr;
   logic [FB_DATAW-1:0] clr_col;
   assign clr_last = state == CLEAR && clr_addr == CW'(FB_PIXELS - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         clr_addr <= '0;
         clr_col  <= '0;
      end else if (accept) begin
         clr_addr <= '0;
         clr_col  <= clr_cidx;
      end else if (state == CLEAR && !clr_last)
         clr_addr <= clr_addr + CW'(1);
`else
   localparam state_t START_ST = DRAW;
   logic unused_cfg;
   assign unused_cfg = &{1'b0, clr_cidx, FB_PIXELS[0]};
   assign clr_last = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_cidx    <= '0;
         draw_start <= 1'b0;
         overrun    <= 1'b0;
         fb_draw    <= 1'b0;
      end else begin
         state      <= state_nxt;
         fb_we      <= fb_we_nxt;
         fb_addr    <= fb_addr_nxt;
         fb_cidx    <= fb_cidx_nxt;
         draw_start <= start_nxt;
         overrun    <= vbi && busy;
         fb_draw    <= (state == READY && vbi) ? ~fb_draw : fb_draw;
      end
   always_comb begin
      state_nxt = state == CLEAR ? (clr_last ? DRAW : CLEAR) :
                  state == DRAW  ? (draw_done ? READY : DRAW) :
                  accept         ? START_ST : state;
      start_nxt = state != DRAW && state_nxt == DRAW;
   end
   always_comb begin
      busy        = state == CLEAR || state == DRAW;
      fb_we_nxt   = state == DRAW && draw_we;
      fb_addr_nxt = state == DRAW ? draw_addr : fb_addr;
      fb_cidx_nxt = state == DRAW ? draw_cidx : fb_cidx;
`ifdef FB_DB_CLEAR_EN
      if (state == CLEAR) begin
         fb_we_nxt   = 1'b1;
         fb_addr_nxt = FB_ADDRW'(clr_addr);
         fb_cidx_nxt = clr_col;
      end
`endif
   end
endmodule
